uart_tx_engine: RTL and testbench

//  Byte-wide UART transmitter (8N1, LSB first) driving the board-level UART_TX pin of CPU_P.
//  It is the transmit counterpart of the CPU's UART receive path. A small FIFO decouples the
//  CPU store-to-UART peripheral write from serial timing. Frames leave back-to-back while

---
 rtl/uart_tx_engine_pkg.sv | 25 ++
 rtl/uart_tx_engine_fifo.sv | 63 ++++++
 rtl/uart_tx_engine.sv | 135 +++++++++++++
 tb/tb_uart_tx_engine.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_engine_pkg.sv
// ============================================================================
// Module   : uart_tx_engine_pkg
// Brief    : FSM encodings, frame constants and baud divider helper for UART TX
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_engine_pkg;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_start = 2'd1;
  localparam logic [1:0] c_st_data  = 2'd2;
  localparam logic [1:0] c_st_stop  = 2'd3;

  localparam int c_data_bits = 8;
  localparam int c_stop_bits = 1;

  // Shared with the receive path so both sides agree on bit timing.
  function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_engine_fifo.sv
// ============================================================================
// Module   : uart_tx_engine_fifo
// Brief    : Synchronous FIFO queueing bytes for the UART transmitter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_engine_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_full_count = (c_aw + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Full blocks a push even when a pop frees a slot on the same edge.
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;
  assign full     = (r_count == c_full_count);
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_engine.sv
// ============================================================================
// Module   : uart_tx_engine
// Brief    : 8N1 LSB-first UART transmitter with input FIFO, back-to-back frames
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_engine #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sys_clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          UART_TX,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  import uart_tx_engine_pkg::*;

  localparam int c_baud_div = calc_baud_div(CLK_FREQ, BAUD_RATE);
  localparam int c_cnt_w    = (c_baud_div > 1) ? $clog2(c_baud_div) : 1;
  localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(c_baud_div - 1);
  localparam logic [2:0] c_last_data = 3'(c_data_bits - 1);
  localparam logic [2:0] c_last_stop = 3'(c_stop_bits - 1);

  logic [1:0]         r_state;
  logic [c_cnt_w-1:0] r_baud_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_uart_tx;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [7:0]         w_fifo_data;
  logic               w_push;
  logic               w_pop;
  logic               w_bit_done;
  logic               w_frame_end;

  assign w_bit_done  = (r_baud_cnt == c_baud_last);
  assign w_frame_end = (r_state == c_st_stop) && w_bit_done && (r_bit_idx == c_last_stop);
  // Popping on the final stop cycle chains the next start bit with no idle gap.
  assign w_pop       = !w_fifo_empty && ((r_state == c_st_idle) || w_frame_end);
  assign tx_ready    = !w_fifo_full;
  assign w_push      = tx_valid && tx_ready;
  assign tx_busy     = (r_state != c_st_idle) || (fifo_count != '0);
  assign UART_TX     = r_uart_tx;

  uart_tx_engine_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (tx_data),
    .pop       (w_pop),
    .pop_data  (w_fifo_data),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      r_state    <= c_st_idle;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_uart_tx  <= 1'b1;
    end else begin
      // Line register follows the state one cycle later; every bit keeps full width.
      r_uart_tx <= (r_state == c_st_data) ? r_shift[0] : (r_state != c_st_start);
      case (r_state)
        c_st_idle: begin
          r_baud_cnt <= '0;
          r_bit_idx  <= '0;
          if (w_pop) begin
            r_shift <= w_fifo_data;
            r_state <= c_st_start;
          end
        end
        c_st_start: begin
          if (w_bit_done) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_state    <= c_st_data;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        c_st_data: begin
          if (w_bit_done) begin
            r_baud_cnt <= '0;
            r_shift    <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == c_last_data) begin
              r_bit_idx <= '0;
              r_state   <= c_st_stop;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        c_st_stop: begin
          if (w_bit_done) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == c_last_stop) begin
              r_bit_idx <= '0;
              if (w_pop) begin
                r_shift <= w_fifo_data;
                r_state <= c_st_start;
              end else begin
                r_state <= c_st_idle;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
// ============================================================================
// Module   : tb_uart_tx_engine
// Brief    : Directed self-checking bench for uart_tx_engine (BAUD_DIV = 16)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_engine;

  localparam int CLK_FREQ   = 160;
  localparam int BAUD_RATE  = 10;
  localparam int FIFO_DEPTH = 4;

  logic       sys_clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       UART_TX;
  logic       tx_busy;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_fail = 0;
  int mon_err = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  uart_tx_engine #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .UART_TX    (UART_TX),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 sys_clk = ~sys_clk;

  // Line decoder: samples mid-bit on falling edges, abandons a frame on reset.
  int         m_st = 0;
  int         m_cnt = 0;
  logic [7:0] m_sh = 8'h00;
  always @(negedge sys_clk) begin
    if (!reset) begin
      m_st <= 0;
    end else if (m_st == 0) begin
      if (UART_TX === 1'b0) begin
        m_st  <= 1;
        m_cnt <= 1;
      end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 8 && UART_TX !== 1'b0) begin
        mon_err <= mon_err + 1;
        m_st    <= 0;
      end else if (m_cnt > 8 && m_cnt < 152 && ((m_cnt - 8) % 16) == 0) begin
        m_sh <= {UART_TX, m_sh[7:1]};
      end else if (m_cnt == 152) begin
        if (UART_TX === 1'b1) rx_q.push_back(m_sh);
        else mon_err <= mon_err + 1;
        m_st <= 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Holds tx_valid until accepted; returns cycles spent blocked.
  task automatic push_byte(input logic [7:0] b, output int waited);
    logic rdy;
    rdy    = 1'b0;
    waited = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      rdy    = tx_ready;
      waited = k;
      step(1);
      if (rdy) break;
    end
    tx_valid = 1'b0;
    check("push_accepted", 32'(rdy), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (!tx_busy) break;
      step(1);
    end
    check("drain_idle", 32'(tx_busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    w = 0;

    // Reset
    step(5);
    check("rst_line", 32'(UART_TX), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    reset = 1'b1;
    step(1);
    check("post_rst_line", 32'(UART_TX), 32'd1);
    check("post_rst_count", 32'(fifo_count), 32'd0);

    // Single frame 0x55
    tx_data = 8'h55; tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    exp_q.push_back(8'h55);
    check("t1_count_after_accept", 32'(fifo_count), 32'd1);
    check("t1_busy_after_accept", 32'(tx_busy), 32'd1);
    check("t1_line_e0", 32'(UART_TX), 32'd1);
    step(1);
    check("t1_line_e1", 32'(UART_TX), 32'd1);
    check("t1_count_after_pop", 32'(fifo_count), 32'd0);
    step(1);
    check("t1_start_e2", 32'(UART_TX), 32'd0);
    for (int k = 0; k < 10; k++) begin
      step(k == 0 ? 8 : 16);
      check($sformatf("t1_bit%0d", k), 32'(UART_TX), 32'(fbit(8'h55, k)));
    end
    step(6);
    check("t1_busy_e160", 32'(tx_busy), 32'd1);
    step(1);
    check("t1_busy_e161", 32'(tx_busy), 32'd0);
    check("t1_line_idle", 32'(UART_TX), 32'd1);
    step(3);

    // Back-to-back 0xA3, 0x0F: 320 contiguous line cycles
    tx_data = 8'hA3; tx_valid = 1'b1;
    step(1);
    tx_data = 8'h0F;
    step(1);
    tx_valid = 1'b0;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    check("t2_count_push_pop", 32'(fifo_count), 32'd1);
    for (int i = 0; i < 320; i++) begin
      step(1);
      check($sformatf("t2_line_%0d", i), 32'(UART_TX),
            32'(fbit((i < 160) ? 8'hA3 : 8'h0F, (i % 160) / 16)));
      check($sformatf("t2_busy_%0d", i), 32'(tx_busy), 32'(i < 319));
    end
    step(3);

    // Six bytes with tx_valid held: FIFO fills, sixth waits for a slot
    for (int i = 1; i <= 5; i++) begin
      push_byte(8'(i), w);
      exp_q.push_back(8'(i));
      check($sformatf("t3_wait_%0d", i), 32'(w), 32'd0);
    end
    check("t3_count_full", 32'(fifo_count), 32'd4);
    check("t3_ready_full", 32'(tx_ready), 32'd0);
    push_byte(8'h06, w);
    exp_q.push_back(8'h06);
    check("t3_wait_6", 32'(w), 32'd157);
    check("t3_count_refull", 32'(fifo_count), 32'd4);
    wait_idle(1200);
    step(3);

    // Push while full coinciding with a pop is rejected
    push_byte(8'h11, w); exp_q.push_back(8'h11);
    push_byte(8'h22, w); exp_q.push_back(8'h22);
    push_byte(8'h33, w); exp_q.push_back(8'h33);
    push_byte(8'h44, w); exp_q.push_back(8'h44);
    push_byte(8'h77, w); exp_q.push_back(8'h77);
    check("t4_count_full", 32'(fifo_count), 32'd4);
    tx_data = 8'hEE; tx_valid = 1'b1;
    w = -1;
    for (int k = 0; k < 400; k++) begin
      if (tx_ready) begin
        w = k;
        break;
      end
      step(1);
    end
    tx_valid = 1'b0;
    check("t4_full_cycles", 32'(w), 32'd157);
    check("t4_count_after_pop", 32'(fifo_count), 32'd3);
    wait_idle(1000);
    step(3);

    // Reset in the middle of the data bits of 0xFF
    push_byte(8'hFF, w);
    push_byte(8'h99, w);
    step(57);
    check("t5_line_databit", 32'(UART_TX), 32'd1);
    check("t5_busy_pre", 32'(tx_busy), 32'd1);
    check("t5_count_pre", 32'(fifo_count), 32'd1);
    reset = 1'b0;
    step(1);
    check("t5_line_rst", 32'(UART_TX), 32'd1);
    check("t5_count_rst", 32'(fifo_count), 32'd0);
    check("t5_busy_rst", 32'(tx_busy), 32'd0);
    check("t5_ready_rst", 32'(tx_ready), 32'd1);
    reset = 1'b1;
    step(2);
    push_byte(8'h3C, w);
    exp_q.push_back(8'h3C);
    wait_idle(300);
    step(5);

    // Decoded line output
    check("rx_frames", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size())
        check($sformatf("rx_byte_%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
    end
    check("rx_framing", 32'(mon_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
